// File: rtl/write_resp_router.sv
// AXI write-response (B) router: round-robin pick among six slaves, one response
// in flight, steered to M1/M2 by the upper ID nibble, which is stripped on the way out.
module write_resp_router #(
  parameter int          ID_BITS  = 4,
  parameter int          IDS_BITS = 8,
  parameter int unsigned NUM_S    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDS_BITS-1:0] BID_S0,
  input  logic [1:0]          BRESP_S0,
  input  logic                BVALID_S0,
  output logic                BREADY_S0,
  input  logic [IDS_BITS-1:0] BID_S1,
  input  logic [1:0]          BRESP_S1,
  input  logic                BVALID_S1,
  output logic                BREADY_S1,
  input  logic [IDS_BITS-1:0] BID_S2,
  input  logic [1:0]          BRESP_S2,
  input  logic                BVALID_S2,
  output logic                BREADY_S2,
  input  logic [IDS_BITS-1:0] BID_S3,
  input  logic [1:0]          BRESP_S3,
  input  logic                BVALID_S3,
  output logic                BREADY_S3,
  input  logic [IDS_BITS-1:0] BID_S4,
  input  logic [1:0]          BRESP_S4,
  input  logic                BVALID_S4,
  output logic                BREADY_S4,
  input  logic [IDS_BITS-1:0] BID_S5,
  input  logic [1:0]          BRESP_S5,
  input  logic                BVALID_S5,
  output logic                BREADY_S5,
  output logic [ID_BITS-1:0]  BID_M1,
  output logic [1:0]          BRESP_M1,
  output logic                BVALID_M1,
  input  logic                BREADY_M1,
  output logic [ID_BITS-1:0]  BID_M2,
  output logic [1:0]          BRESP_M2,
  output logic                BVALID_M2,
  input  logic                BREADY_M2,
  output logic                resp_drop
);

  localparam int GW = $clog2(NUM_S);
  localparam int MW = IDS_BITS - ID_BITS;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         pick;
  logic                  found;
  logic                  hs;
  logic [IDS_BITS-1:0]   bid    [NUM_S];
  logic [1:0]            bresp  [NUM_S];
  logic [NUM_S-1:0]      bvalid;
  logic [NUM_S-1:0]      bready;
  logic [IDS_BITS-1:0]   gid;
  logic [MW-1:0]         mst;

  assign bid[0] = BID_S0;  assign bresp[0] = BRESP_S0;
  assign bid[1] = BID_S1;  assign bresp[1] = BRESP_S1;
  assign bid[2] = BID_S2;  assign bresp[2] = BRESP_S2;
  assign bid[3] = BID_S3;  assign bresp[3] = BRESP_S3;
  assign bid[4] = BID_S4;  assign bresp[4] = BRESP_S4;
  assign bid[5] = BID_S5;  assign bresp[5] = BRESP_S5;
  assign bvalid = {BVALID_S5, BVALID_S4, BVALID_S3, BVALID_S2, BVALID_S1, BVALID_S0};
  assign {BREADY_S5, BREADY_S4, BREADY_S3, BREADY_S2, BREADY_S1, BREADY_S0} = bready;

  assign gid = bid[grant];
  assign mst = gid[IDS_BITS-1:ID_BITS];

  // First asserted BVALID at or after rr_ptr, wrapping past the last slave.
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] sel;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_S; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_S) idx = idx - NUM_S;
      sel = GW'(idx);
      if (!found && bvalid[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  always_comb begin
    bready    = '0;
    BVALID_M1 = 1'b0;
    BID_M1    = '0;
    BRESP_M1  = '0;
    BVALID_M2 = 1'b0;
    BID_M2    = '0;
    BRESP_M2  = '0;
    resp_drop = 1'b0;
    hs        = 1'b0;
    if (state == BUSY) begin
      if (mst == MW'(1)) begin
        BVALID_M1     = bvalid[grant];
        BID_M1        = gid[ID_BITS-1:0];
        BRESP_M1      = bresp[grant];
        bready[grant] = BREADY_M1;
      end else if (mst == MW'(2)) begin
        BVALID_M2     = bvalid[grant];
        BID_M2        = gid[ID_BITS-1:0];
        BRESP_M2      = bresp[grant];
        bready[grant] = BREADY_M2;
      end else begin
        // Unmapped master: accept and discard so the slave is not stalled forever.
        bready[grant] = 1'b1;
        resp_drop     = bvalid[grant];
      end
      hs = bvalid[grant] & bready[grant];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            state  <= IDLE;
            rr_ptr <= (grant == GW'(NUM_S - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
